operand_fetch_ctrl: RTL and testbench
=====================================

// Module: operand_fetch_ctrl
// PURPOSE
//  Sequencer for the PE operand register pair (A: rs1/busA/PC, B: rs2/busB/imm).
//  Decodes the opcode class of each accepted instruction and drives Asel/Bsel/Aenable/Benable.
//  Handshakes with the neighbour CGRA buses when an operand is routed from a bus.
//  Presents op_valid to the ALU once both operands are latched.
// PARAMETERS
//  CNT_W        16   width of stall_cycles counter
//  TIMEOUT_CYC  255  bus-wait limit in cycles (used only with OFC_TIMEOUT_EN)
// PORTS
//  clk           in   1      clock, all logic on rising edge
//  reset         in   1      synchronous, active-low reset
//  instr_valid   in   1      instruction available from decode
//  instr_ready   out  1      controller accepts an instruction
//  opcode        in   7      RV32I opcode[6:0]
//  cfg_a_bus     in   1      A operand taken from busA instead of rs1 (sampled with instr)
//  cfg_b_bus     in   1      B operand taken from busB instead of rs2 (sampled with instr)
//  busA_valid    in   1      busA data valid
//  busA_ack      out  1      busA data consumed this cycle
//  busB_valid    in   1      busB data valid
//  busB_ack      out  1      busB data consumed this cycle
//  Asel          out  2      00 rs1, 01 busA, 10 PC
//  Bsel          out  2      00 rs2, 01 busB, 10 imm
//  Aenable       out  1      load A register
//  Benable       out  1      load B register
//  op_valid      out  1      operands ready for the ALU
//  alu_ready     in   1      ALU accepts operands
//  illegal_instr out  1      1-cycle pulse on an undecodable opcode
//  timeout       out  1      1-cycle pulse on bus-wait abort (0 without OFC_TIMEOUT_EN)
//  stall_cycles  out  CNT_W  saturating count of WAIT cycles spent on bus operands
// BEHAVIOUR
//  Reset (reset==0 at an edge): state IDLE; Asel=Bsel=00; all enables, acks, op_valid,
//   illegal_instr and timeout =0; stall_cycles=0; any in-flight instruction is dropped.
//  Decode: OP 0110011 and BRANCH 1100011 -> A=rs1, B=rs2.
//   OP-IMM 0010011, LOAD 0000011, STORE 0100011, JALR 1100111, LUI 0110111 -> A=rs1, B=imm.
//   AUIPC 0010111, JAL 1101111 -> A=PC, B=imm. Any other opcode is illegal.
//   cfg_a_bus turns rs1 into busA (01); cfg_b_bus turns rs2 into busB (01). PC and imm are never overridden.
//  FSM states:
//   IDLE: instr_ready=1.
//    On instr_valid, latch the decode. Illegal -> pulse illegal_instr next cycle and stay in IDLE.
//    Legal -> WAIT. Asel/Bsel take the decoded values on entry to WAIT.
//   WAIT: instr_ready=0.
//    Local operands (rs/PC/imm) get their enable in the first WAIT cycle.
//    A bus operand gets enable=1 and ack=1 in the same cycle its bus valid is high.
//    busA and busB may both be captured in one cycle.
//    Each enable fires exactly once per instruction. A bus valid that arrives after capture, or outside WAIT, gets ack=0.
//    Once both operands are captured (including in the capturing cycle) -> ISSUE.
//    stall_cycles +1 for each WAIT cycle with a bus operand still outstanding; it saturates at all-ones.
//   ISSUE: op_valid=1, Asel/Bsel held, enables=0.
//    On alu_ready -> IDLE. instr_ready is high the following cycle, giving no back-to-back overlap.
//  Latency, all-local instruction: accepted at edge 0, enables high in cycle 1, op_valid high in cycle 2.
//  Asel/Bsel change only on entry to WAIT; they are stable through ISSUE.
// CONFIGURATION
//  OFC_TIMEOUT_EN defined: an 8..CNT_W-bit wait counter is cleared on entry to WAIT.
//   If it reaches TIMEOUT_CYC with a bus operand outstanding: pulse timeout, go to IDLE, op_valid never asserted.
//   Already-captured registers are left unchanged.
//  OFC_TIMEOUT_EN undefined: WAIT persists indefinitely; timeout is tied 0.
// TESTING
//  T1 opcode=0110011, cfg=00 -> Asel=00, Bsel=00; Aenable=Benable=1 in cycle 1; op_valid in cycle 2.
//  T2 opcode=0010111 -> Asel=10, Bsel=10; with alu_ready=0 for 3 cycles, op_valid holds and instr_ready stays 0.
//  T3 opcode=0010011, cfg_a_bus=1, busA_valid after 4 cycles -> Aenable in cycle 1 (Asel=01 side) only on valid;
//     Benable in cycle 1; busA_ack 1 cycle; stall_cycles=4.
//  T4 opcode=0110011, cfg=11, busA and busB valid in the same cycle -> both acks and enables in one cycle, then ISSUE.
//  T5 opcode=1111111 -> illegal_instr pulse, no enables, instr_ready stays 1.
//     reset=0 in WAIT -> all outputs at reset values next cycle.
//  T6 (OFC_TIMEOUT_EN, TIMEOUT_CYC=8) cfg_b_bus=1, busB_valid never -> timeout pulse after 8 WAIT cycles; IDLE; no op_valid.

Source files
------------

// File: rtl/operand_fetch_ctrl_if.sv
// Handshake and bus bundle between decode/CGRA neighbours and the operand fetch controller.
// The master side is the environment (decode, buses, ALU); the slave side is the controller.
interface operand_fetch_ctrl_if #(
    parameter int CNT_W = 16
) ();
    logic             instr_valid;
    logic             instr_ready;
    logic [6:0]       opcode;
    logic             cfg_a_bus;
    logic             cfg_b_bus;
    logic             busA_valid;
    logic             busA_ack;
    logic             busB_valid;
    logic             busB_ack;
    logic [1:0]       Asel;
    logic [1:0]       Bsel;
    logic             Aenable;
    logic             Benable;
    logic             op_valid;
    logic             alu_ready;
    logic             illegal_instr;
    logic             timeout;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output instr_valid,
        output opcode,
        output cfg_a_bus,
        output cfg_b_bus,
        output busA_valid,
        output busB_valid,
        output alu_ready,
        input  instr_ready,
        input  busA_ack,
        input  busB_ack,
        input  Asel,
        input  Bsel,
        input  Aenable,
        input  Benable,
        input  op_valid,
        input  illegal_instr,
        input  timeout,
        input  stall_cycles
    );

    modport slave (
        input  instr_valid,
        input  opcode,
        input  cfg_a_bus,
        input  cfg_b_bus,
        input  busA_valid,
        input  busB_valid,
        input  alu_ready,
        output instr_ready,
        output busA_ack,
        output busB_ack,
        output Asel,
        output Bsel,
        output Aenable,
        output Benable,
        output op_valid,
        output illegal_instr,
        output timeout,
        output stall_cycles
    );
endinterface

// File: rtl/operand_fetch_ctrl.sv
// Operand A/B fetch sequencer for a CGRA PE: decodes the opcode class, loads operands, issues to the ALU.
// Optional bus-wait abort is enabled by defining OFC_TIMEOUT_EN.
module operand_fetch_ctrl #(
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 255
) (
    input logic                 clk,
    input logic                 reset,
    operand_fetch_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WAIT  = 2'b01,
        ST_ISSUE = 2'b10
    } state_t;

    localparam logic [1:0] SEL_REG = 2'b00;
    localparam logic [1:0] SEL_BUS = 2'b01;
    localparam logic [1:0] SEL_ALT = 2'b10;

    if ((CNT_W < 8) || (TIMEOUT_CYC < 1) || ((CNT_W < 31) && (TIMEOUT_CYC >= (1 << CNT_W)))) begin : g_param_check
        $error("operand_fetch_ctrl: CNT_W must be >= 8 and TIMEOUT_CYC must fit in CNT_W bits");
    end

    // Returns {legal, a_sel, b_sel} for an RV32I major opcode, before any bus override.
    function automatic logic [4:0] decode_op(input logic [6:0] op);
        logic [4:0] res;
        case (op)
            7'b0110011, 7'b1100011:
                res = {1'b1, SEL_REG, SEL_REG};
            7'b0010011, 7'b0000011, 7'b0100011, 7'b1100111, 7'b0110111:
                res = {1'b1, SEL_REG, SEL_ALT};
            7'b0010111, 7'b1101111:
                res = {1'b1, SEL_ALT, SEL_ALT};
            default:
                res = {1'b0, SEL_REG, SEL_REG};
        endcase
        return res;
    endfunction

    state_t           r_state;
    logic [1:0]       r_a_sel;
    logic [1:0]       r_b_sel;
    logic             r_a_en;
    logic             r_b_en;
    logic             r_a_pend;
    logic             r_b_pend;
    logic             r_op_valid;
    logic             r_illegal;
    logic [CNT_W-1:0] r_stall;

`ifdef OFC_TIMEOUT_EN
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_timeout;
`endif

    logic [4:0] w_dec;
    logic       w_legal;
    logic [1:0] w_a_sel;
    logic [1:0] w_b_sel;
    logic       w_a_cap;
    logic       w_b_cap;
    logic       w_a_left;
    logic       w_b_left;
    logic       w_stall_sat;

    // Decode of the offered instruction; a bus route only replaces a register-file source.
    always_comb begin
        w_dec   = decode_op(bus.opcode);
        w_legal = w_dec[4];
        if (bus.cfg_a_bus && (w_dec[3:2] == SEL_REG)) begin
            w_a_sel = SEL_BUS;
        end else begin
            w_a_sel = w_dec[3:2];
        end
        if (bus.cfg_b_bus && (w_dec[1:0] == SEL_REG)) begin
            w_b_sel = SEL_BUS;
        end else begin
            w_b_sel = w_dec[1:0];
        end
    end

    // Bus capture happens in the same cycle the neighbour's valid is seen, so ack is not delayed.
    always_comb begin
        w_a_cap     = (r_state == ST_WAIT) && r_a_pend && bus.busA_valid;
        w_b_cap     = (r_state == ST_WAIT) && r_b_pend && bus.busB_valid;
        w_a_left    = (r_state == ST_WAIT) && r_a_pend && !bus.busA_valid;
        w_b_left    = (r_state == ST_WAIT) && r_b_pend && !bus.busB_valid;
        w_stall_sat = &r_stall;
    end

    assign bus.instr_ready   = (r_state == ST_IDLE);
    assign bus.busA_ack      = w_a_cap;
    assign bus.busB_ack      = w_b_cap;
    assign bus.Asel          = r_a_sel;
    assign bus.Bsel          = r_b_sel;
    assign bus.Aenable       = r_a_en | w_a_cap;
    assign bus.Benable       = r_b_en | w_b_cap;
    assign bus.op_valid      = r_op_valid;
    assign bus.illegal_instr = r_illegal;
    assign bus.stall_cycles  = r_stall;
`ifdef OFC_TIMEOUT_EN
    assign bus.timeout       = r_timeout;
`else
    assign bus.timeout       = 1'b0;
`endif

    // Sequencer: IDLE accepts, WAIT collects operands, ISSUE holds them until the ALU takes them.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_a_sel    <= SEL_REG;
            r_b_sel    <= SEL_REG;
            r_a_en     <= 1'b0;
            r_b_en     <= 1'b0;
            r_a_pend   <= 1'b0;
            r_b_pend   <= 1'b0;
            r_op_valid <= 1'b0;
            r_illegal  <= 1'b0;
            r_stall    <= '0;
`ifdef OFC_TIMEOUT_EN
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
`endif
        end else begin
            r_illegal <= 1'b0;
`ifdef OFC_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (bus.instr_valid) begin
                        if (w_legal) begin
                            r_state  <= ST_WAIT;
                            r_a_sel  <= w_a_sel;
                            r_b_sel  <= w_b_sel;
                            r_a_en   <= (w_a_sel != SEL_BUS);
                            r_b_en   <= (w_b_sel != SEL_BUS);
                            r_a_pend <= (w_a_sel == SEL_BUS);
                            r_b_pend <= (w_b_sel == SEL_BUS);
`ifdef OFC_TIMEOUT_EN
                            r_wait_cnt <= '0;
`endif
                        end else begin
                            r_illegal <= 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    r_a_en <= 1'b0;
                    r_b_en <= 1'b0;
                    if (w_a_cap) begin
                        r_a_pend <= 1'b0;
                    end
                    if (w_b_cap) begin
                        r_b_pend <= 1'b0;
                    end
                    if (w_a_left || w_b_left) begin
                        if (!w_stall_sat) begin
                            r_stall <= r_stall + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
`ifdef OFC_TIMEOUT_EN
                        // Abort drops the instruction; operands already loaded stay as they are.
                        if (r_wait_cnt == WAIT_LAST) begin
                            r_state   <= ST_IDLE;
                            r_a_pend  <= 1'b0;
                            r_b_pend  <= 1'b0;
                            r_timeout <= 1'b1;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
`endif
                    end else begin
                        r_state    <= ST_ISSUE;
                        r_op_valid <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (bus.alu_ready) begin
                        r_state    <= ST_IDLE;
                        r_op_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_a_en     <= 1'b0;
                    r_b_en     <= 1'b0;
                    r_a_pend   <= 1'b0;
                    r_b_pend   <= 1'b0;
                    r_op_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_operand_fetch_ctrl.sv
// Directed-vector bench for operand_fetch_ctrl; expected values are hand-derived per cycle.
module tb_operand_fetch_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   n_vec  = 0;
    int   n_miss = 0;

    operand_fetch_ctrl_if #(.CNT_W(16)) bus_if ();

    operand_fetch_ctrl #(
        .CNT_W       (16),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus_if.instr_valid = 1'b0;
        bus_if.opcode      = 7'b0000000;
        bus_if.cfg_a_bus   = 1'b0;
        bus_if.cfg_b_bus   = 1'b0;
        bus_if.busA_valid  = 1'b0;
        bus_if.busB_valid  = 1'b0;
        bus_if.alu_ready   = 1'b0;
    endtask

    // Offers one instruction, accepts it on the next edge, returns settled in cycle 1.
    task automatic issue(input logic [6:0] op, input logic a_bus, input logic b_bus);
        bus_if.instr_valid = 1'b1;
        bus_if.opcode      = op;
        bus_if.cfg_a_bus   = a_bus;
        bus_if.cfg_b_bus   = b_bus;
        #1;
        check_eq("accept_ready", bus_if.instr_ready, 32'd1);
        next_cycle();
        bus_if.instr_valid = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        next_cycle();
        next_cycle();
        check_eq("rst_ready",   bus_if.instr_ready,   32'd1);
        check_eq("rst_opv",     bus_if.op_valid,      32'd0);
        check_eq("rst_asel",    bus_if.Asel,          32'd0);
        check_eq("rst_bsel",    bus_if.Bsel,          32'd0);
        check_eq("rst_aen",     bus_if.Aenable,       32'd0);
        check_eq("rst_ben",     bus_if.Benable,       32'd0);
        check_eq("rst_stall",   bus_if.stall_cycles,  32'd0);
        check_eq("rst_illegal", bus_if.illegal_instr, 32'd0);
        check_eq("rst_timeout", bus_if.timeout,       32'd0);
        reset = 1'b1;
        next_cycle();

        // T1: R-type, all local
        issue(7'b0110011, 1'b0, 1'b0);
        bus_if.alu_ready = 1'b1;
        check_eq("t1_asel", bus_if.Asel,        32'd0);
        check_eq("t1_bsel", bus_if.Bsel,        32'd0);
        check_eq("t1_aen",  bus_if.Aenable,     32'd1);
        check_eq("t1_ben",  bus_if.Benable,     32'd1);
        check_eq("t1_opv1", bus_if.op_valid,    32'd0);
        check_eq("t1_rdy1", bus_if.instr_ready, 32'd0);
        next_cycle();
        check_eq("t1_opv2", bus_if.op_valid,    32'd1);
        check_eq("t1_aen2", bus_if.Aenable,     32'd0);
        check_eq("t1_ben2", bus_if.Benable,     32'd0);
        next_cycle();
        check_eq("t1_rdy3", bus_if.instr_ready, 32'd1);
        check_eq("t1_opv3", bus_if.op_valid,    32'd0);
        bus_if.alu_ready = 1'b0;

        // T2: AUIPC, ALU stalls for three cycles
        issue(7'b0010111, 1'b0, 1'b0);
        check_eq("t2_asel", bus_if.Asel,    32'd2);
        check_eq("t2_bsel", bus_if.Bsel,    32'd2);
        check_eq("t2_aen",  bus_if.Aenable, 32'd1);
        check_eq("t2_ben",  bus_if.Benable, 32'd1);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            check_eq("t2_hold_opv",  bus_if.op_valid,    32'd1);
            check_eq("t2_hold_rdy",  bus_if.instr_ready, 32'd0);
            check_eq("t2_hold_asel", bus_if.Asel,        32'd2);
            check_eq("t2_hold_bsel", bus_if.Bsel,        32'd2);
        end
        next_cycle();
        bus_if.alu_ready = 1'b1;
        check_eq("t2_opv_last", bus_if.op_valid, 32'd1);
        next_cycle();
        bus_if.alu_ready = 1'b0;
        check_eq("t2_rdy_back", bus_if.instr_ready, 32'd1);
        check_eq("t2_opv_gone", bus_if.op_valid,    32'd0);

        // T3: OP-IMM with A from busA, valid arrives in the fifth WAIT cycle
        issue(7'b0010011, 1'b1, 1'b0);
        check_eq("t3_asel", bus_if.Asel,     32'd1);
        check_eq("t3_bsel", bus_if.Bsel,     32'd2);
        check_eq("t3_aen1", bus_if.Aenable,  32'd0);
        check_eq("t3_ben1", bus_if.Benable,  32'd1);
        check_eq("t3_ack1", bus_if.busA_ack, 32'd0);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            check_eq("t3_wait_aen", bus_if.Aenable,  32'd0);
            check_eq("t3_wait_ben", bus_if.Benable,  32'd0);
            check_eq("t3_wait_ack", bus_if.busA_ack, 32'd0);
        end
        next_cycle();
        bus_if.busA_valid = 1'b1;
        #1;
        check_eq("t3_cap_aen", bus_if.Aenable,  32'd1);
        check_eq("t3_cap_ack", bus_if.busA_ack, 32'd1);
        check_eq("t3_cap_ben", bus_if.Benable,  32'd0);
        check_eq("t3_cap_opv", bus_if.op_valid, 32'd0);
        next_cycle();
        check_eq("t3_late_ack", bus_if.busA_ack,     32'd0);
        check_eq("t3_late_aen", bus_if.Aenable,      32'd0);
        check_eq("t3_opv",      bus_if.op_valid,     32'd1);
        check_eq("t3_stall",    bus_if.stall_cycles, 32'd4);
        bus_if.alu_ready = 1'b1;
        next_cycle();
        check_eq("t3_idle_ack", bus_if.busA_ack,    32'd0);
        check_eq("t3_idle_rdy", bus_if.instr_ready, 32'd1);
        bus_if.busA_valid = 1'b0;
        bus_if.alu_ready  = 1'b0;

        // T4: both operands from buses, captured together in cycle 2
        issue(7'b0110011, 1'b1, 1'b1);
        check_eq("t4_asel", bus_if.Asel,    32'd1);
        check_eq("t4_bsel", bus_if.Bsel,    32'd1);
        check_eq("t4_aen1", bus_if.Aenable, 32'd0);
        check_eq("t4_ben1", bus_if.Benable, 32'd0);
        next_cycle();
        bus_if.busA_valid = 1'b1;
        bus_if.busB_valid = 1'b1;
        #1;
        check_eq("t4_aack", bus_if.busA_ack, 32'd1);
        check_eq("t4_back", bus_if.busB_ack, 32'd1);
        check_eq("t4_aen2", bus_if.Aenable,  32'd1);
        check_eq("t4_ben2", bus_if.Benable,  32'd1);
        next_cycle();
        bus_if.busA_valid = 1'b0;
        bus_if.busB_valid = 1'b0;
        #1;
        check_eq("t4_opv",   bus_if.op_valid,     32'd1);
        check_eq("t4_stall", bus_if.stall_cycles, 32'd5);
        bus_if.alu_ready = 1'b1;
        next_cycle();
        bus_if.alu_ready = 1'b0;
        check_eq("t4_rdy", bus_if.instr_ready, 32'd1);

        // T5: undecodable opcode
        issue(7'b1111111, 1'b0, 1'b0);
        check_eq("t5_illegal", bus_if.illegal_instr, 32'd1);
        check_eq("t5_rdy",     bus_if.instr_ready,   32'd1);
        check_eq("t5_aen",     bus_if.Aenable,       32'd0);
        check_eq("t5_ben",     bus_if.Benable,       32'd0);
        next_cycle();
        check_eq("t5_pulse_end", bus_if.illegal_instr, 32'd0);
        check_eq("t5_no_opv",    bus_if.op_valid,      32'd0);

`ifdef OFC_TIMEOUT_EN
        // T6: busB never arrives, abort after eight WAIT cycles
        issue(7'b0110011, 1'b0, 1'b1);
        check_eq("t6_to1", bus_if.timeout, 32'd0);
        for (int i = 0; i < 7; i++) begin
            next_cycle();
            check_eq("t6_wait_to",  bus_if.timeout,  32'd0);
            check_eq("t6_wait_opv", bus_if.op_valid, 32'd0);
        end
        next_cycle();
        check_eq("t6_pulse", bus_if.timeout,     32'd1);
        check_eq("t6_rdy",   bus_if.instr_ready, 32'd1);
        check_eq("t6_opv",   bus_if.op_valid,    32'd0);
        next_cycle();
        check_eq("t6_pulse_end", bus_if.timeout,  32'd0);
        check_eq("t6_opv_end",   bus_if.op_valid, 32'd0);
`endif

        // Reset while waiting on busB drops the instruction
        issue(7'b0110011, 1'b0, 1'b1);
        check_eq("rw_bsel", bus_if.Bsel,    32'd1);
        check_eq("rw_aen",  bus_if.Aenable, 32'd1);
        check_eq("rw_ben",  bus_if.Benable, 32'd0);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            check_eq("rw_wait_to",  bus_if.timeout,     32'd0);
            check_eq("rw_wait_rdy", bus_if.instr_ready, 32'd0);
            check_eq("rw_wait_opv", bus_if.op_valid,    32'd0);
        end
        reset = 1'b0;
        next_cycle();
        bus_if.busB_valid = 1'b1;
        #1;
        check_eq("rw_rdy",   bus_if.instr_ready,  32'd1);
        check_eq("rw_asel",  bus_if.Asel,         32'd0);
        check_eq("rw_bsel0", bus_if.Bsel,         32'd0);
        check_eq("rw_stall", bus_if.stall_cycles, 32'd0);
        check_eq("rw_aen0",  bus_if.Aenable,      32'd0);
        check_eq("rw_ben0",  bus_if.Benable,      32'd0);
        check_eq("rw_back",  bus_if.busB_ack,     32'd0);
        check_eq("rw_opv",   bus_if.op_valid,     32'd0);
        reset = 1'b1;
        bus_if.busB_valid = 1'b0;
        next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
